// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests program bytes over a req/ack handshake,
// prefetches into a 2-entry buffer and loads ir/pc on ir_load; pc_load redirects.
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ir_load,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_avail,
    output logic              stall,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] fetch_addr_r;
    logic [ADDR_W-1:0] discard_addr_r;
    logic [ADDR_W-1:0] buf_addr_r [2];
    logic [DATA_W-1:0] buf_data_r [2];
    logic [1:0]        count_r;
    logic [1:0]        count_post_s;
    logic [1:0]        count_next_s;
    logic              pop_s;
    logic              push_s;
    logic [DATA_W-1:0] ir_r;
    logic [ADDR_W-1:0] pc_r;
    logic              ir_avail_r;

    // Buffer bookkeeping: a redirect suppresses both pop and push on its edge.
    always_comb begin
        pop_s        = ir_load && (count_r != 2'd0) && !pc_load;
        push_s       = (state_r == ST_REQ) && mem_ack && !pc_load;
        count_post_s = count_r - {1'b0, pop_s};
        if (pc_load) begin
            count_next_s = 2'd0;
        end else begin
            count_next_s = count_post_s + {1'b0, push_s};
        end
        stall = ir_load && (count_r == 2'd0);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a new request is issued only while the buffer has
    // room for its data once any pending transaction has landed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pc_load || (count_post_s < 2'd2)) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (pc_load) begin
                    if (mem_ack) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    // After this push one slot must still be free for the next read.
                    if (count_post_s == 2'd0) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (mem_ack) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: DISCARD keeps the abandoned address on the bus until its ack.
    always_comb begin
        mem_req = (state_r == ST_REQ) || (state_r == ST_DISCARD);
        if (state_r == ST_DISCARD) begin
            mem_addr = discard_addr_r;
        end else begin
            mem_addr = fetch_addr_r;
        end
    end

    // Fetch address, prefetch buffer and instruction register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_addr_r   <= '0;
            discard_addr_r <= '0;
            count_r        <= 2'd0;
            ir_r           <= '0;
            pc_r           <= '0;
            ir_avail_r     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_addr_r[i] <= '0;
                buf_data_r[i] <= '0;
            end
        end else begin
            count_r    <= count_next_s;
            ir_avail_r <= (count_next_s != 2'd0);
            if (pc_load) begin
                fetch_addr_r <= pc_target;
                if ((state_r == ST_REQ) && !mem_ack) begin
                    discard_addr_r <= fetch_addr_r;
                end
            end else begin
                if (pop_s) begin
                    ir_r          <= buf_data_r[0];
                    pc_r          <= buf_addr_r[0];
                    buf_addr_r[0] <= buf_addr_r[1];
                    buf_data_r[0] <= buf_data_r[1];
                end
                if (push_s) begin
                    buf_addr_r[count_post_s[0]] <= fetch_addr_r;
                    buf_data_r[count_post_s[0]] <= mem_rdata;
                    fetch_addr_r <= fetch_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign ir       = ir_r;
    assign pc       = pc_r;
    assign ir_avail = ir_avail_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: random memory latency, ir_load and
// redirects checked against a queue-based model of the fetch stream.
module tb_instr_fetch;

    logic       clock = 1'b0;
    logic       reset;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       ir_load;
    logic [7:0] ir;
    logic [7:0] pc;
    logic       ir_avail;
    logic       stall;
    logic       pc_load;
    logic [7:0] pc_target;

    instr_fetch #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_load(ir_load), .ir(ir),
        .pc(pc), .ir_avail(ir_avail), .stall(stall), .pc_load(pc_load),
        .pc_target(pc_target)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: addresses of buffered bytes, next sequential fetch
    // address, and whether the outstanding read belongs to an old stream.
    logic [7:0] q[$];
    logic [7:0] m_next;
    logic [7:0] m_stale_addr;
    logic [7:0] m_ir;
    logic [7:0] m_pc;
    bit         m_stale;
    bit         started;
    int         lat;
    int         lat_max;
    int         ack_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_val(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    task automatic model_reset();
        q.delete();
        m_next = 8'h00; m_stale_addr = 8'h00; m_ir = 8'h00; m_pc = 8'h00;
        m_stale = 1'b0; started = 1'b0; lat = 0; ack_count = 0;
    endtask

    // One clock period, entered and left at a falling edge.
    task automatic cycle(input logic irl, input logic pcl, input logic [7:0] tgt);
        logic ack;
        logic exp_req;
        exp_req = m_stale || (q.size() < 2);
        check_val("ir", ir, m_ir);
        check_val("pc", pc, m_pc);
        check_val("ir_avail", ir_avail, q.size() != 0);
        if (started) check_val("mem_req", mem_req, exp_req);
        if (started && exp_req) check_val("mem_addr", mem_addr, m_stale ? m_stale_addr : m_next);
        if (mem_req === 1'b1) ack = (lat == 0);
        else ack = ($urandom_range(0, 7) == 0);
        ir_load   = irl;
        pc_load   = pcl;
        pc_target = tgt;
        mem_ack   = ack;
        mem_rdata = ack ? mem_val(mem_addr) : 8'($urandom);
        #1;
        check_val("stall", stall, irl && (q.size() == 0));
        if (pcl) begin
            if ((mem_req === 1'b1) && !ack) begin
                if (!m_stale) m_stale_addr = m_next;
                m_stale = 1'b1;
            end else begin
                m_stale = 1'b0;
            end
            q.delete();
            m_next = tgt;
        end else begin
            if (irl && (q.size() > 0)) begin
                m_pc = q.pop_front();
                m_ir = mem_val(m_pc);
            end
            if ((mem_req === 1'b1) && ack) begin
                if (m_stale) m_stale = 1'b0;
                else begin
                    q.push_back(m_next);
                    m_next = m_next + 8'h01;
                end
            end
        end
        if ((mem_req === 1'b1) && ack) begin
            ack_count++;
            lat = $urandom_range(0, lat_max);
        end else if ((mem_req === 1'b1) && (lat > 0)) begin
            lat--;
        end
        @(negedge clock);
        started = 1'b1;
    endtask

    // Asserts reset between edges (checking the async clear), releases it at a falling edge.
    task automatic do_reset(input bit check_pre);
        #2;
        if (check_pre) check_val("req_pre_rst", mem_req, m_stale || (q.size() < 2));
        reset = 1'b0;
        ir_load = 1'b0; pc_load = 1'b0; mem_ack = 1'b0; pc_target = 8'h00; mem_rdata = 8'h00;
        #1;
        check_val("rst_mem_req", mem_req, 1'b0);
        check_val("rst_ir", ir, 8'h00);
        check_val("rst_pc", pc, 8'h00);
        check_val("rst_ir_avail", ir_avail, 1'b0);
        @(negedge clock);
        @(negedge clock);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] prev_pc;
        bit         saw_wrap;
        bit         got;
        logic [7:0] first_pc;
        logic [7:0] first_ir;
        reset = 1'b0;
        lat_max = 0;
        model_reset();
        @(negedge clock);
        do_reset(1'b0);

        // Zero-wait memory, ir_load held high from reset release.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (i >= 2) begin
                check_val("zw_ir", ir, 8'h10 + 8'(i - 2));
                check_val("zw_pc", pc, 8'(i - 2));
                check_val("zw_stall", stall, 1'b0);
            end
        end
        // Redirect and ack on the same edge while ir_load is high.
        cycle(1'b1, 1'b1, 8'h80);
        check_val("same_edge_addr", mem_addr, 8'h80);
        cycle(1'b1, 1'b0, 8'h00);
        do_reset(1'b1);

        // No ir_load: buffer fills with exactly two reads then requests stop.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
        check_val("fill_reads", ack_count, 2);
        check_val("fill_idle", mem_req, 1'b0);
        cycle(1'b1, 1'b0, 8'h00);
        check_val("fill_ir", ir, 8'h10);
        check_val("fill_next_req", mem_req, 1'b1);
        check_val("fill_next_addr", mem_addr, 8'h02);
        do_reset(1'b0);

        // Redirect to 0x40 while a slow read of address 0 is outstanding.
        cycle(1'b0, 1'b0, 8'h00);
        lat = 3;
        cycle(1'b0, 1'b1, 8'h40);
        check_val("discard_addr", mem_addr, 8'h00);
        got = 1'b0; first_pc = 8'h00; first_ir = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (!got && (ir !== 8'h00)) begin
                got = 1'b1; first_pc = pc; first_ir = ir;
            end
        end
        check_val("redir_pc", first_pc, 8'h40);
        check_val("redir_ir", first_ir, 8'h50);

        // Address wrap from 0xFF to 0x00.
        cycle(1'b1, 1'b1, 8'hFD);
        saw_wrap = 1'b0;
        prev_pc = pc;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if ((prev_pc == 8'hFF) && (pc == 8'h00)) saw_wrap = 1'b1;
            prev_pc = pc;
        end
        check_val("wrap", saw_wrap, 1'b1);

        // Random latency, loads and redirects.
        lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 8'($urandom));
        end
        lat_max = 0;
        lat = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
        do_reset(1'b1);
        cycle(1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
